// File: rtl/reg_dump_reader.sv
// Snapshots up to eight registers on start and streams the selected ones out
// over a valid/ready channel in ascending index order. Define REG_DUMP_PARITY_EN to add out_par.
module reg_dump_reader #(
    parameter int DW = 9
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic              start,
    input  logic [7:0]        mask,
    input  logic [8*DW-1:0]   regs_flat,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [2:0]        out_idx,
    output logic [DW-1:0]     out_data,
    output logic              busy,
    output logic              done
`ifdef REG_DUMP_PARITY_EN
    ,
    output logic              out_par
`endif
);

    typedef enum logic {IDLE, SEND} state_t;

    state_t         state, state_nxt;
    logic [7:0]     snap_mask, snap_mask_nxt;
    logic [DW-1:0]  snap_data [8];
    logic           done_nxt;
    logic           capture;
    logic [2:0]     low_idx;
    logic [7:0]     low_bit;

    // Lowest set bit of the remaining mask is always the current beat.
    always_comb begin
        low_idx = '0;
        for (int i = 7; i >= 0; i--) begin
            if (snap_mask[i]) low_idx = 3'(i);
        end
        low_bit = 8'(1) << low_idx;
    end

    // NOTE: every signal written here gets a default first, so no latch is inferred.
    always_comb begin
        state_nxt     = state;
        snap_mask_nxt = snap_mask;
        done_nxt      = 1'b0;
        capture       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (mask == 8'h00) begin
                        done_nxt = 1'b1;
                    end else begin
                        capture       = 1'b1;
                        snap_mask_nxt = mask;
                        state_nxt     = SEND;
                    end
                end
            end
            SEND: begin
                if (out_ready) begin
                    snap_mask_nxt = snap_mask & ~low_bit;
                    if (snap_mask_nxt == 8'h00) begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (Reset) begin
            state     <= IDLE;
            snap_mask <= '0;
            done      <= 1'b0;
        end else begin
            state     <= state_nxt;
            snap_mask <= snap_mask_nxt;
            done      <= done_nxt;
        end
    end

    // NOTE: the data snapshot is not reset; it is only visible while out_valid is high.
    always_ff @(posedge clk) begin
        if (capture && !Reset) begin
            for (int i = 0; i < 8; i++) begin
                snap_data[i] <= regs_flat[i*DW +: DW];
            end
        end
    end

    always_comb begin
        out_valid = (state == SEND);
        busy      = (state == SEND);
        out_idx   = out_valid ? low_idx : 3'd0;
        out_data  = out_valid ? snap_data[low_idx] : '0;
    end

`ifdef REG_DUMP_PARITY_EN
    // out_data is already zero when idle, so the parity is too.
    assign out_par = ^out_data;
`endif

endmodule

// File: doc/reg_dump_reader.md
REG_DUMP_READER -- requirements
Module: reg_dump_reader

Interface
REQ-001 SHALL have parameter DW, default 9: width of each register value.
REQ-002 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-003 SHALL have port Reset  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port start  input  1  request a dump; sampled only in IDLE.
REQ-005 SHALL have port mask  input  8  registers to dump; bit i selects register i.
REQ-006 SHALL have port regs_flat  input  8*DW  live register values; register i at bits [i*DW +: DW].
REQ-007 SHALL have port out_ready  input  1  consumer accepts the current beat.
REQ-008 SHALL have port out_valid  output  1  out_idx/out_data hold a valid beat.
REQ-009 SHALL have port out_idx  output  3  index of the register in the current beat.
REQ-010 SHALL have port out_data  output  DW  snapshotted value of register out_idx.
REQ-011 SHALL have port busy  output  1  high while a dump is in progress.
REQ-012 SHALL have port done  output  1  one-cycle pulse when a dump completes.

Function
REQ-013 SHALL implement states IDLE and SEND; busy = (state == SEND).
REQ-014 In IDLE, start=1 with mask!=0 SHALL capture regs_flat and mask into snapshot registers and enter SEND.
REQ-015 In IDLE, start=1 with mask==0 SHALL pulse done on the next cycle, emit no beats, and stay in IDLE.
REQ-016 start while in SEND SHALL be ignored; the snapshot SHALL not change.
REQ-017 First beat: out_valid SHALL be high the cycle after start is accepted, carrying the lowest-index set bit of the captured mask.
REQ-018 Beats SHALL be emitted in ascending index order, one per selected register, each exactly once.
REQ-019 A beat SHALL complete on a rising edge with out_valid=1 and out_ready=1; its mask bit is then cleared.
REQ-020 While out_valid=1 and out_ready=0, out_idx and out_data SHALL hold stable.
REQ-021 After a non-final handshake, the next beat SHALL be valid in the following cycle, allowing one beat per cycle.
REQ-022 After the final handshake: the next cycle SHALL have out_valid=0, busy=0, done=1, and state IDLE.
REQ-023 A new start SHALL be accepted in the same cycle that done=1.
REQ-024 out_data SHALL come from the snapshot; changes on regs_flat during SEND SHALL not affect the output.
REQ-025 out_valid SHALL be 0 in IDLE; out_idx/out_data SHALL be 0 whenever out_valid=0.

Reset
REQ-026 Reset=1 SHALL force IDLE, out_valid=0, out_idx=0, out_data=0, busy=0, done=0, snapshot mask=0.
REQ-027 Reset during SEND SHALL abort the dump without a done pulse; Reset SHALL take priority over start and handshakes.

Configuration
REQ-028 With macro REG_DUMP_PARITY_EN defined, SHALL add output out_par (1 bit).
- out_par = XOR of out_data (even parity), valid with out_valid.
- out_par is 0 when out_valid=0 or in reset.
REQ-029 Without REG_DUMP_PARITY_EN, port out_par SHALL not exist; all other behaviour is identical.

Verification
REQ-030 Reset then idle: all outputs 0; start=1, mask=0 -> done=1 for exactly one cycle, no out_valid.
REQ-031 Full-speed dump: mask=8'b1010_0101, reg i = i*3, out_ready=1 -> beats (0,0),(2,6),(5,15),(7,21) on four consecutive cycles, then done.
REQ-032 Backpressure: mask=8'h80, reg7=9'h1AB, out_ready low 3 cycles -> out_idx=7, out_data=9'h1AB held stable; one handshake, then done.
REQ-033 Snapshot and overlap: change regs_flat and pulse start during SEND -> outputs keep captured values; start ignored; beat count unchanged.
REQ-034 Reset mid-dump: mask=8'hFF, assert Reset after 2nd handshake -> all outputs 0 next cycle, no done pulse; next start runs normally.
REQ-035 With REG_DUMP_PARITY_EN: out_data=9'h0F3 -> out_par=0; 9'h0F7 -> out_par=1.
